// File: rtl/data_memory_responder.sv
// Word-addressed data memory with a fixed request-to-response latency.
// Writes commit at acceptance; reads load read_data on entry to the response cycle.
module data_memory_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_memory_read,
   input  logic        data_memory_write,
   input  logic [31:0] data_address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        data_memory_response,
   output logic        access_fault_o
);
   // state | meaning
   // IDLE  | waiting for a read or write strobe
   // WAIT  | latency down-counter running
   // RESP  | one-cycle completion pulse

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state, state_next;
   logic [3:0]    cnt, cnt_next;
   logic [AW-1:0] idx_q, idx_in, rd_idx;
   logic          in_range_q, in_range_in, rd_in_range;
   logic          is_read_q, is_read_in;
   logic          accept, load_rd;
   logic          unused_addr_bits;
   logic [31:0]   mem [DEPTH_WORDS];

   assign idx_in           = data_address[AW+1:2];
   assign in_range_in      = (data_address[31:AW+2] == '0);
   assign is_read_in       = data_memory_read & ~data_memory_write;
   assign accept           = (state == IDLE) & (data_memory_read | data_memory_write) & ~rst;
   assign unused_addr_bits = ^data_address[1:0];

   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      load_rd     = 1'b0;
      rd_idx      = idx_q;
      rd_in_range = in_range_q;
      case (state)
         IDLE: begin
            if (data_memory_read | data_memory_write) begin
               // Single-cycle latency reads straight from the presented address.
               rd_idx      = idx_in;
               rd_in_range = in_range_in;
               if (LATENCY == 1) begin
                  state_next = RESP;
                  load_rd    = is_read_in;
               end else begin
                  state_next = WAIT;
                  cnt_next   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_next = RESP;
               load_rd    = is_read_q;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         read_data  <= 32'd0;
         idx_q      <= '0;
         in_range_q <= 1'b1;
         is_read_q  <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (accept) begin
            idx_q      <= idx_in;
            in_range_q <= in_range_in;
            is_read_q  <= is_read_in;
         end
         if (load_rd)
            read_data <= rd_in_range ? mem[rd_idx] : 32'd0;
      end
   end

   // Storage is deliberately outside the reset domain.
   always_ff @(posedge clk) begin
      if (accept & data_memory_write & in_range_in)
         mem[idx_in] <= write_data;
   end

   assign data_memory_response = (state == RESP) & ~rst;
   assign access_fault_o       = (state == RESP) & ~in_range_q & ~rst;

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two, minimum 4.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to response; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port data_memory_read, input, 1 bit: read request strobe, level or pulse.
REQ-006 SHALL have port data_memory_write, input, 1 bit: write request strobe, level or pulse.
REQ-007 SHALL have port data_address, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-008 SHALL have port write_data, input, 32 bits: full-word write value.
REQ-009 SHALL have port read_data, output, 32 bits: read result.
REQ-010 SHALL have port data_memory_response, output, 1 bit: completion pulse.
REQ-011 SHALL have port access_fault_o, output, 1 bit: the completing access was out of range.

Function
REQ-012 SHALL implement states IDLE, WAIT and RESP.
REQ-013 In IDLE, a request (read OR write high) SHALL be accepted at the rising edge; address, write_data and type are captured at that edge.
REQ-014 When read and write are both high at acceptance, the request SHALL be treated as a write; no read is performed.
REQ-015 Word index SHALL be data_address[log2(DEPTH_WORDS)+1:2]; the access is in range when data_address[31:log2(DEPTH_WORDS)+2] is all zero.
REQ-016 An in-range write SHALL be committed to storage at the accepting edge, as a whole word.
REQ-017 With LATENCY=1, acceptance SHALL go to RESP. Otherwise it SHALL go to WAIT with a down-counter loaded with LATENCY-2, and WAIT goes to RESP when the counter is 0.
REQ-018 data_memory_response SHALL be high during exactly one cycle, the RESP cycle, which is LATENCY cycles after the accepting edge.
REQ-019 RESP SHALL return to IDLE unconditionally, so a strobe still high in the cycle after RESP is accepted as a new request using the address present in that cycle.
REQ-020 Strobes and address changes during WAIT and RESP SHALL be ignored.
REQ-021 For an in-range read, read_data SHALL be loaded on entry to RESP with the addressed word, reflecting every write committed earlier.
REQ-022 read_data SHALL hold its value until the next read enters RESP; writes SHALL NOT change read_data.
REQ-023 An out-of-range read SHALL load read_data with 0.
REQ-024 An out-of-range write SHALL not modify storage.
REQ-025 access_fault_o SHALL be high only during the RESP cycle of an out-of-range access; it is 0 at all other times.
REQ-026 Back-to-back throughput SHALL be one access per LATENCY+1 cycles with the strobe held.

Reset
REQ-027 While rst is high, the block SHALL enter IDLE, clear the counter, and drive data_memory_response, access_fault_o and read_data to 0.
REQ-028 rst asserted during WAIT or RESP SHALL abort the access with no response pulse; a write already committed at acceptance stays committed.
REQ-029 Storage contents SHALL NOT be altered by reset.
REQ-030 No request SHALL be accepted at an edge where rst is high.

Verification
REQ-031 Bench SHALL cover: LATENCY=2; write 0xDEADBEEF to address 0x10 (one-cycle pulse), then read 0x10 -> response 2 cycles after each acceptance, read_data=0xDEADBEEF, fault 0.
REQ-032 Bench SHALL cover: read strobe held high with address stepping 0x21 then 0x25 on each response (unaligned-pair pattern) -> words 0x20 and 0x24 returned, responses spaced 3 cycles apart.
REQ-033 Bench SHALL cover: read and write both high, address 0x8, data 0x12345678 -> write performed, read_data unchanged, a later read of 0x8 returns 0x12345678.
REQ-034 Bench SHALL cover: DEPTH_WORDS=1024, read 0x1000 and write 0x1004 -> response with fault=1, read_data=0, storage unchanged.
REQ-035 Bench SHALL cover: rst pulsed in WAIT after a write to 0x0 -> no response pulse, outputs 0, a subsequent read of 0x0 returns the written word.
REQ-036 Bench SHALL cover: LATENCY=1 -> response in the cycle after acceptance, and a held strobe yields one response every 2 cycles.
